fetch_unit: RTL
===============

// Module: fetch_unit
// PURPOSE
//  Instruction-fetch stage of the RV32I pipeline: upstream producer of the INSTRUCTION word the decode stage consumes.
//  Owns the PC and issues single-outstanding requests to instruction memory.
//  Loads the IF/ID pipeline register (instruction + PC); honours decode stall and branch redirect from MEM.
// PARAMETERS
//  RESET_PC   32'h0000_0000  PC value loaded on reset
//  NOP_INSTR  32'h0000_0013  bubble word (ADDI x0,x0,0) driven when IF/ID holds no valid instruction
// PORTS
//  clk            in   1   clock, all state on rising edge
//  rst            in   1   synchronous, active-high reset
//  IMEM_REQ       out  1   registered one-cycle request pulse, address on IMEM_ADDR
//  IMEM_ADDR      out  32  word-aligned fetch address
//  IMEM_RVALID    in   1   response valid, >=1 cycle after IMEM_REQ
//  IMEM_RDATA     in   32  instruction word, valid with IMEM_RVALID
//  STALL          in   1   decode hazard: hold IF/ID contents
//  BRANCH_TAKEN   in   1   redirect fetch, flush IF/ID
//  BRANCH_TARGET  in   32  redirect address (bits [1:0] forced to 0)
//  INSTRUCTION    out  32  IF/ID instruction to decode
//  PC_OUT         out  32  IF/ID PC of INSTRUCTION
//  INSTR_VALID    out  1   IF/ID holds a real instruction
//  FETCH_CNT      out  32  instructions delivered   (FETCH_PERF_CNT_EN only)
//  STALL_CNT      out  32  cycles with STALL=1      (FETCH_PERF_CNT_EN only)
// BEHAVIOUR
//  - Reset: PC=RESET_PC, state=FETCH, IMEM_REQ=0, IMEM_ADDR=RESET_PC, INSTRUCTION=NOP_INSTR, PC_OUT=0, INSTR_VALID=0, counters=0.
//  - One request outstanding max; IMEM_REQ never asserted outside FETCH.
//  - FSM:
//    FETCH: IMEM_REQ=1, IMEM_ADDR=PC -> WAIT.
//    WAIT:  RVALID & !STALL -> load IF/ID {RDATA,PC,1}, PC+=4 -> FETCH.
//           RVALID & STALL -> capture into hold reg -> HOLD.
//           else stay.
//    HOLD:  !STALL -> load IF/ID from hold reg, PC+=4 -> FETCH; else stay.
//    DRAIN: discard in-flight response; RVALID -> FETCH (PC already = target).
//  - Priority: rst > BRANCH_TAKEN > STALL > normal.
//  - BRANCH_TAKEN (any state):
//    - PC <= {BRANCH_TARGET[31:2],2'b00}; IF/ID <= {NOP_INSTR, PC_OUT unchanged, 0}; hold reg discarded.
//    - Next state DRAIN if request outstanding (WAIT, no RVALID this cycle), else FETCH.
//    - RVALID in the same cycle as the branch is dropped.
//  - STALL=1 (no branch): IF/ID holds all three outputs unchanged; PC frozen.
//  - No instruction delivered this cycle and STALL=0: IF/ID <= {NOP_INSTR, PC_OUT unchanged, 0} (bubble).
//  - PC arithmetic mod 2^32: 32'hFFFF_FFFC + 4 wraps to 0, no flag.
//  - Latency: REQ at cycle n; 1-cycle memory -> RVALID n+1 -> IF/ID valid n+2.
//    Steady-state throughput 1 instruction / 2 cycles.
//  - rst mid-transaction: returns to FETCH at RESET_PC; late RVALID arriving in FETCH is ignored.
// CONFIGURATION
//  FETCH_PERF_CNT_EN defined:
//    - FETCH_CNT increments on each IF/ID load with INSTR_VALID=1.
//    - STALL_CNT increments each cycle STALL=1.
//    - Both wrap at 2^32; both cleared by rst.
//  Undefined: FETCH_CNT and STALL_CNT tied to 32'h0; no counter flops.
// TESTING
//  T1 reset: rst=1 two cycles -> IMEM_ADDR=0, INSTR_VALID=0, INSTRUCTION=32'h13; first IMEM_REQ on cycle after rst falls.
//  T2 sequential fetch, 1-cycle memory returning 0x00500093, 0x00A00113 ->
//     IF/ID shows (0x00500093, PC 0x0), then (0x00A00113, PC 0x4), 2 cycles apart.
//  T3 stall on response: STALL=1 while RVALID(0x002081B3) ->
//     IF/ID frozen; word appears with PC_OUT=0x8 the cycle after STALL drops; no duplicate request.
//  T4 branch in WAIT: BRANCH_TAKEN, target 0x0000_0043 ->
//     PC=0x40, INSTR_VALID=0; stale RVALID dropped in DRAIN; next IMEM_ADDR=0x40.
//  T5 branch + STALL + RVALID same cycle -> branch wins: IF/ID flushed, FSM to FETCH, IMEM_ADDR=target.
//  T6 wrap: RESET_PC=32'hFFFF_FFFC -> fetch at 0xFFFF_FFFC then 0x0;
//     with FETCH_PERF_CNT_EN, 3 stall cycles -> STALL_CNT=3.

Source files
------------

// File: rtl/fetch_unit.sv
// fetch_unit: RV32I instruction-fetch stage, owns the PC and IF/ID register.
// Optional macro FETCH_PERF_CNT_EN adds the FETCH_CNT/STALL_CNT counters.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   IMEM_REQ/ADDR            registered fetch request pulse and address
//   IMEM_RVALID/RDATA        instruction memory response
//   STALL, BRANCH_*          decode hold, redirect from MEM
//   INSTRUCTION/PC_OUT/      IF/ID register contents
//   INSTR_VALID
//   FETCH_CNT, STALL_CNT     perf counters (zero when the macro is undefined)
module fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  output logic        IMEM_REQ,
  output logic [31:0] IMEM_ADDR,
  input  logic        IMEM_RVALID,
  input  logic [31:0] IMEM_RDATA,
  input  logic        STALL,
  input  logic        BRANCH_TAKEN,
  input  logic [31:0] BRANCH_TARGET,
  output logic [31:0] INSTRUCTION,
  output logic [31:0] PC_OUT,
  output logic        INSTR_VALID,
  output logic [31:0] FETCH_CNT,
  output logic [31:0] STALL_CNT
);

  localparam logic [1:0] S_FETCH = 2'd0;
  localparam logic [1:0] S_WAIT  = 2'd1;
  localparam logic [1:0] S_HOLD  = 2'd2;
  localparam logic [1:0] S_DRAIN = 2'd3;

  logic [1:0]  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pc_out_q, pc_out_d;
  logic [31:0] hold_q, hold_d;
  logic        valid_q, valid_d;
  logic        req_q, req_d;
  logic        load;
  logic [31:0] load_data;
  logic        busy;

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    instr_d   = instr_q;
    pc_out_d  = pc_out_q;
    valid_d   = valid_q;
    hold_d    = hold_q;
    load      = 1'b0;
    load_data = hold_q;
    // A request issued this cycle (FETCH with REQ high) is in flight
    // too, so a redirect then must also drain its response.
    busy = ((state_q == S_FETCH) && req_q) ||
           (((state_q == S_WAIT) || (state_q == S_DRAIN)) &&
            !IMEM_RVALID);
    if (BRANCH_TAKEN) begin
      pc_d    = BRANCH_TARGET & ~32'h3;
      instr_d = NOP_INSTR;
      valid_d = 1'b0;
      state_d = busy ? S_DRAIN : S_FETCH;
    end else begin
      unique case (state_q)
        // REQ low in FETCH only right after reset: wait one cycle
        S_FETCH: if (req_q) state_d = S_WAIT;
        S_WAIT: begin
          if (IMEM_RVALID) begin
            if (STALL) begin
              hold_d  = IMEM_RDATA;
              state_d = S_HOLD;
            end else begin
              load      = 1'b1;
              load_data = IMEM_RDATA;
              state_d   = S_FETCH;
            end
          end
        end
        S_HOLD: begin
          if (!STALL) begin
            load    = 1'b1;
            state_d = S_FETCH;
          end
        end
        S_DRAIN: if (IMEM_RVALID) state_d = S_FETCH;
        default: state_d = S_FETCH;
      endcase
      if (load) begin
        instr_d  = load_data;
        pc_out_d = pc_q;
        valid_d  = 1'b1;
        pc_d     = pc_q + 32'd4;
      end else if (!STALL) begin
        instr_d = NOP_INSTR;
        valid_d = 1'b0;
      end
    end
    req_d = (state_d == S_FETCH);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_FETCH;
      pc_q     <= RESET_PC;
      instr_q  <= NOP_INSTR;
      pc_out_q <= '0;
      valid_q  <= 1'b0;
      hold_q   <= '0;
      req_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      instr_q  <= instr_d;
      pc_out_q <= pc_out_d;
      valid_q  <= valid_d;
      hold_q   <= hold_d;
      req_q    <= req_d;
    end
  end

  assign IMEM_REQ    = req_q;
  assign IMEM_ADDR   = pc_q;
  assign INSTRUCTION = instr_q;
  assign PC_OUT      = pc_out_q;
  assign INSTR_VALID = valid_q;

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fcnt_q, fcnt_d;
  logic [31:0] scnt_q, scnt_d;

  always_comb begin
    fcnt_d = fcnt_q + {31'd0, load};
    scnt_d = scnt_q + {31'd0, STALL};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fcnt_q <= '0;
      scnt_q <= '0;
    end else begin
      fcnt_q <= fcnt_d;
      scnt_q <= scnt_d;
    end
  end

  assign FETCH_CNT = fcnt_q;
  assign STALL_CNT = scnt_q;
`else
  assign FETCH_CNT = 32'h0;
  assign STALL_CNT = 32'h0;
`endif

endmodule
